drv_arbiter: RTL and testbench
==============================

DRV_ARBITER -- requirements
Module: drv_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (legal range 2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the data width of each requester and of the owned register.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port req, input, NREQ bits: request from requester i on bit i, level, held until grant is seen.
REQ-006 The block SHALL have port wdata, input, NREQ*WIDTH bits: write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port gnt, output, NREQ bits: registered one-hot grant; high for exactly one cycle per grant.
REQ-008 The block SHALL have port q, output, WIDTH bits: the single-driver owned register.
REQ-009 The block SHALL have port q_valid, output, 1 bit: one-cycle pulse, high in the cycle q was just written.
REQ-010 The block SHALL have port q_src, output, $clog2(NREQ) bits: index of the requester that last wrote q.
REQ-011 The block SHALL have port conflict_cnt, output, 8 bits: saturating count of contended arbitration edges.

Function
REQ-012 The block SHALL be the only driver of q; all requesters reach q solely through arbitration, so simultaneous writers never race or multiply drive q.
REQ-013 The block SHALL compute an eligible mask at each rising edge: elig = req & ~gnt. A requester granted at edge k SHALL be excluded at edge k+1.
REQ-014 The block SHALL grant at most one requester per edge, and only when elig is non-zero.
REQ-015 The block SHALL arbitrate round-robin: the search starts at index (last+1) mod NREQ and ascends with wrap-around; the first eligible index wins.
REQ-016 The block SHALL update last to the winning index on each grant and SHALL leave it unchanged on edges without a grant.
REQ-017 On a grant to requester i, the block SHALL set, at the same edge: gnt to one-hot bit i, q to wdata slice i, q_valid to 1, and q_src to i. Latency from req sampled to these outputs SHALL be one cycle.
REQ-018 On an edge with elig equal to 0, the block SHALL set gnt and q_valid to 0 and SHALL hold q and q_src.
REQ-019 The block SHALL sample wdata only on the granting edge; wdata changes at any other time SHALL have no effect.
REQ-020 A requester still holding req in the cycle after its gnt SHALL be treated as a new request at the following edge. It is then lower priority than every other eligible requester.
REQ-021 The block SHALL increment conflict_cnt by 1 on each edge where popcount(elig) >= 2, and SHALL saturate it at 8'hFF with no wrap.
REQ-022 The block SHALL tolerate req being deasserted before grant with no effect: the requester is simply not eligible.

Reset
REQ-023 While reset is high at a rising edge, the block SHALL set gnt to 0, q to 0, q_valid to 0, q_src to 0, conflict_cnt to 0, and last to NREQ-1, so that requester 0 has first priority.
REQ-024 Reset SHALL take priority over any simultaneous request. A grant in flight SHALL be discarded, and q SHALL NOT be written on that edge.
REQ-025 The first edge after reset deasserts SHALL arbitrate normally from the reset state.

Verification (NREQ=4, WIDTH=8)
REQ-026 Scenario: reset, then req=4'b0100 with slice 2 = 8'hA5 for one edge -> next cycle gnt=4'b0100, q=8'hA5, q_valid=1, q_src=2; the following cycle gnt=0, q_valid=0, q holds 8'hA5.
REQ-027 Scenario: after reset, hold req=4'b1111 continuously with slices 8'h10/8'h11/8'h12/8'h13 -> grants appear in order 0,1,2,3,0 on consecutive cycles; q follows 8'h10, 8'h11, 8'h12, 8'h13, 8'h10; conflict_cnt increments every edge.
REQ-028 Scenario: req=4'b0001 held for 3 edges -> gnt toggles 1,0,1; q_valid=1,0,1. The back-to-back grant is blocked by the mask.
REQ-029 Scenario: force more than 255 contended edges -> conflict_cnt reaches 8'hFF and stays at 8'hFF.
REQ-030 Scenario: reset asserted on the same edge as req=4'b0010 -> q=0, gnt=0, q_valid=0. The first grant after release goes to requester 1 if it is still requesting.
REQ-031 Scenario: last=1 with req=4'b0001|4'b1000 -> requester 3 is granted before requester 0 (wrap-around order).

Source files
------------

// File: rtl/drv_arbiter.sv
// -----------------------------------------------------------------------------
// drv_arbiter
//   Round-robin arbiter that owns a single data register q. Any number of
//   requesters may ask to write q in the same cycle; exactly one wins per clock
//   edge, so q only ever has one driver.
//
// Parameters
//   NREQ  - number of requesters (2..8)
//   WIDTH - data width of each requester slice and of q
//
// Ports
//   clk          - clock, all state updates on the rising edge
//   reset        - synchronous active-high reset
//   req          - per-requester level request, bit i = requester i
//   wdata        - packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt          - registered one-hot grant, one cycle per grant
//   q            - the owned register
//   q_valid      - pulses high in the cycle q was just written
//   q_src        - index of the requester that last wrote q
//   conflict_cnt - saturating count of edges with two or more eligible
// -----------------------------------------------------------------------------
module drv_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [WIDTH-1:0]          q,
    output logic                      q_valid,
    output logic [$clog2(NREQ)-1:0]   q_src,
    output logic [7:0]                conflict_cnt
);

    localparam int IDXW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [IDXW-1:0] last_r;
    logic [NREQ-1:0] elig_s;
    logic [IDXW-1:0] win_s;
    logic [IDXW-1:0] idx_s;
    logic            found_s;
    logic            contend_s;

    // A requester granted on the previous edge sits out this one, which
    // also pushes it behind everyone else in the round-robin order.
    assign elig_s = req & ~gnt;

    // Two or more eligible bits: clearing the lowest set bit leaves something.
    assign contend_s = |(elig_s & (elig_s - ONE_HOT0));

    // Round-robin pick: scan upward from last+1 with wrap, first eligible wins.
    always_comb begin
        win_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = IDXW'((int'(last_r) + k) % NREQ);
            if (!found_s && elig_s[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant, owned register, pointer and conflict counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt          <= '0;
            q            <= '0;
            q_valid      <= 1'b0;
            q_src        <= '0;
            conflict_cnt <= 8'h00;
            last_r       <= IDXW'(NREQ - 1);
        end else begin
            if (found_s) begin
                gnt     <= ONE_HOT0 << win_s;
                q       <= wdata[int'(win_s)*WIDTH +: WIDTH];
                q_valid <= 1'b1;
                q_src   <= win_s;
                last_r  <= win_s;
            end else begin
                gnt     <= '0;
                q_valid <= 1'b0;
            end
            if (contend_s && (conflict_cnt != 8'hFF)) begin
                conflict_cnt <= conflict_cnt + 8'h01;
            end else begin
                conflict_cnt <= conflict_cnt;
            end
        end
    end

endmodule

// File: tb/tb_drv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_drv_arbiter
//   Self-checking bench for drv_arbiter (NREQ=4, WIDTH=8). Directed scenarios
//   check against literal expectations; a randomized run checks every cycle
//   against a behavioural round-robin model kept in this file.
// -----------------------------------------------------------------------------
module tb_drv_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        q_valid;
    logic [1:0]  q_src;
    logic [7:0]  conflict_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [3:0] m_gnt;
    logic [7:0] m_q;
    logic       m_qv;
    logic [1:0] m_src;
    int         m_cnt;
    int         m_last;

    drv_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .wdata        (wdata),
        .gnt          (gnt),
        .q            (q),
        .q_valid      (q_valid),
        .q_src        (q_src),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge worth of inputs, advance the model, sample 1 time unit
    // after the edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] wd);
        logic [3:0] elig;
        int         w;
        @(negedge clk);
        reset = r;
        req   = rq;
        wdata = wd;
        @(posedge clk);
        if (r) begin
            m_gnt = 4'b0; m_q = 8'h00; m_qv = 1'b0; m_src = 2'd0;
            m_cnt = 0; m_last = 3;
        end else begin
            elig = rq & ~m_gnt;
            if ($countones(elig) >= 2) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m_last + k) % 4;
                if (w < 0 && elig[i]) w = i;
            end
            if (w >= 0) begin
                m_gnt  = 4'(1 << w);
                m_q    = wd[w*8 +: 8];
                m_qv   = 1'b1;
                m_src  = 2'(w);
                m_last = w;
            end else begin
                m_gnt = 4'b0;
                m_qv  = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 4'b1111, 32'hDEADBEEF);
        step(1'b1, 4'b0000, 32'h0);
        n_checks++;
        if ({gnt, q, q_valid, q_src, conflict_cnt} !== 23'd0)
            $display("FAIL reset_state: got gnt=%b q=%h qv=%b src=%0d cnt=%0d, expected all zero",
                     gnt, q, q_valid, q_src, conflict_cnt);
        else n_pass++;
    endtask

    task automatic test_single();
        step(1'b1, 4'b0000, 32'h0);
        step(1'b0, 4'b0100, 32'h77A5_3311);
        n_checks++;
        if (gnt !== 4'b0100 || q !== 8'hA5 || q_valid !== 1'b1 || q_src !== 2'd2)
            $display("FAIL single_grant: got gnt=%b q=%h qv=%b src=%0d, expected 0100 a5 1 2",
                     gnt, q, q_valid, q_src);
        else n_pass++;
        step(1'b0, 4'b0000, 32'h1122_3344);
        n_checks++;
        if (gnt !== 4'b0000 || q !== 8'hA5 || q_valid !== 1'b0 || q_src !== 2'd2)
            $display("FAIL single_hold: got gnt=%b q=%h qv=%b src=%0d, expected 0000 a5 0 2",
                     gnt, q, q_valid, q_src);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        step(1'b1, 4'b0000, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b1111, 32'h1312_1110);
            n_checks++;
            if (gnt !== 4'(1 << order[k]) || q !== 8'(8'h10 + order[k]) ||
                conflict_cnt !== 8'(k + 1))
                $display("FAIL round_robin[%0d]: got gnt=%b q=%h cnt=%0d, expected gnt=%b q=%h cnt=%0d",
                         k, gnt, q, conflict_cnt, 4'(1 << order[k]), 8'(8'h10 + order[k]), k + 1);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic exp [3] = '{1'b1, 1'b0, 1'b1};
        step(1'b1, 4'b0000, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'b0001, 32'h0000_005C);
            n_checks++;
            if (gnt !== {3'b000, exp[k]} || q_valid !== exp[k])
                $display("FAIL back_to_back[%0d]: got gnt=%b qv=%b, expected gnt=%b qv=%b",
                         k, gnt, q_valid, {3'b000, exp[k]}, exp[k]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 4'b0000, 32'h0);
        step(1'b0, 4'b0010, 32'h0000_2200);
        step(1'b0, 4'b1001, 32'hD300_00C0);
        n_checks++;
        if (gnt !== 4'b1000 || q !== 8'hD3 || q_src !== 2'd3)
            $display("FAIL wrap_first: got gnt=%b q=%h src=%0d, expected 1000 d3 3", gnt, q, q_src);
        else n_pass++;
        step(1'b0, 4'b0001, 32'hD300_00C0);
        n_checks++;
        if (gnt !== 4'b0001 || q !== 8'hC0 || q_src !== 2'd0)
            $display("FAIL wrap_second: got gnt=%b q=%h src=%0d, expected 0001 c0 0", gnt, q, q_src);
        else n_pass++;
    endtask

    task automatic test_reset_collision();
        step(1'b1, 4'b0000, 32'h0);
        step(1'b0, 4'b0100, 32'h00EE_0000);
        step(1'b1, 4'b0010, 32'h0000_4400);
        n_checks++;
        if (q !== 8'h00 || gnt !== 4'b0000 || q_valid !== 1'b0)
            $display("FAIL reset_collision: got q=%h gnt=%b qv=%b, expected 00 0000 0", q, gnt, q_valid);
        else n_pass++;
        step(1'b0, 4'b0010, 32'h0000_4400);
        n_checks++;
        if (gnt !== 4'b0010 || q !== 8'h44 || q_src !== 2'd1)
            $display("FAIL after_release: got gnt=%b q=%h src=%0d, expected 0010 44 1", gnt, q, q_src);
        else n_pass++;
    endtask

    task automatic test_saturation();
        step(1'b1, 4'b0000, 32'h0);
        for (int k = 1; k <= 300; k++) begin
            step(1'b0, 4'b1111, $urandom);
            if (k == 254 || k == 255 || k == 300) begin
                n_checks++;
                if (conflict_cnt !== ((k >= 255) ? 8'hFF : 8'(k)))
                    $display("FAIL saturate[%0d]: got cnt=%0d, expected %0d",
                             k, conflict_cnt, (k >= 255) ? 255 : k);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        step(1'b1, 4'b0000, 32'h0);
        for (int k = 0; k < 500; k++) begin
            step(($urandom_range(0, 49) == 0), 4'($urandom), $urandom);
            n_checks++;
            if (gnt !== m_gnt || q !== m_q || q_valid !== m_qv || q_src !== m_src ||
                conflict_cnt !== 8'(m_cnt))
                $display("FAIL random[%0d]: got gnt=%b q=%h qv=%b src=%0d cnt=%0d, expected gnt=%b q=%h qv=%b src=%0d cnt=%0d",
                         k, gnt, q, q_valid, q_src, conflict_cnt, m_gnt, m_q, m_qv, m_src, m_cnt);
            else n_pass++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        req    = 4'b0000;
        wdata  = 32'h0;
        m_gnt  = 4'b0; m_q = 8'h00; m_qv = 1'b0; m_src = 2'd0;
        m_cnt  = 0;    m_last = 3;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_wrap();
        test_reset_collision();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
